// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: register geometry and write-back source encoding.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic SRC_EX  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin arbiter between the execute and load write-back sources.
module wb_rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_ex,
  input  logic i_req_mem,
  output logic o_gnt_ex,
  output logic o_gnt_mem
);
  import rv32i_pkg::*;

  logic r_prio;
  logic w_prio_next;

  always_comb begin
    o_gnt_ex    = 1'b0;
    o_gnt_mem   = 1'b0;
    w_prio_next = r_prio;
    if (rst_n) begin
      if (i_req_ex && i_req_mem) begin
        if (r_prio == SRC_MEM) o_gnt_mem = 1'b1;
        else                   o_gnt_ex  = 1'b1;
      end else if (i_req_ex) begin
        o_gnt_ex = 1'b1;
      end else if (i_req_mem) begin
        o_gnt_mem = 1'b1;
      end
      // Priority passes to whichever source lost (or did not request).
      if (o_gnt_ex)  w_prio_next = SRC_MEM;
      if (o_gnt_mem) w_prio_next = SRC_EX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prio <= SRC_MEM;
    else        r_prio <= w_prio_next;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-back scheduler: shares the single write port between
// execute and load results and keeps the busy scoreboard that stalls decode.
module regfile_wb_scheduler #(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter int AW   = rv32i_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic [AW-1:0]   address3,
  output logic [XLEN-1:0] wr,
  output logic            we
);
  import rv32i_pkg::*;

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_gnt_ex;
  logic            w_gnt_mem;
  logic            w_any_gnt;
  logic [AW-1:0]   w_gnt_rd;
  logic [XLEN-1:0] w_gnt_data;
  logic            w_accept;
  logic            w_set_en;
  logic            w_clr_en;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wr;

  wb_rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_ex  (ex_valid),
    .i_req_mem (mem_valid),
    .o_gnt_ex  (w_gnt_ex),
    .o_gnt_mem (w_gnt_mem)
  );

  assign ex_ready   = w_gnt_ex;
  assign mem_ready  = w_gnt_mem;
  assign w_any_gnt  = w_gnt_ex | w_gnt_mem;
  assign w_gnt_rd   = w_gnt_mem ? mem_rd   : ex_rd;
  assign w_gnt_data = w_gnt_mem ? mem_data : ex_data;

  // x0 is never tracked, so it can never stall an operand read.
  assign w_busy = {r_busy[NREG-1:1], 1'b0};

  assign issue_stall = (issue_valid & (w_busy[issue_rs1] | w_busy[issue_rs2] |
                                       (issue_we & w_busy[issue_rd]))) | flush;
  assign w_accept    = issue_valid & ~issue_stall;
  assign w_set_en    = w_accept & issue_we & (issue_rd != '0);
  assign w_clr_en    = r_we & (r_addr != '0);

  assign w_busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      // Clear beats set if both ever land on the same register.
      assign w_busy_next[gi] =
        flush                                   ? 1'b0 :
        (w_clr_en && (r_addr   == AW'(gi)))     ? 1'b0 :
        (w_set_en && (issue_rd == AW'(gi)))     ? 1'b1 :
                                                  r_busy[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  // A grant to x0 completes the handshake but never raises we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_wr   <= '0;
    end else begin
      r_we <= w_any_gnt & (w_gnt_rd != '0);
      if (w_any_gnt) begin
        r_addr <= w_gnt_rd;
        r_wr   <= w_gnt_data;
      end
    end
  end

  assign we       = r_we;
  assign address3 = r_addr;
  assign wr       = r_wr;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration order, scoreboard
// stalls, x0 drop, flush and mid-operation reset.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  address3;
  logic [31:0] wr;
  logic        we;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_rd       (ex_rd),
    .ex_data     (ex_data),
    .ex_ready    (ex_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .address3    (address3),
    .wr          (wr),
    .we          (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Busy probe: a non-writing issue reading only rs1 stalls iff busy[r].
  task automatic probe(input string tag, input logic [4:0] r, input logic exp_busy);
    issue_valid = 1'b1;
    issue_we    = 1'b0;
    issue_rs1   = r;
    issue_rs2   = 5'd0;
    #1;
    chk(tag, {31'd0, issue_stall}, {31'd0, exp_busy});
    issue_valid = 1'b0;
    issue_rs1   = 5'd0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0; flush = 1'b0;
    ex_valid = 1'b1; ex_rd = '0; ex_data = '0;
    mem_valid = 1'b1; mem_rd = '0; mem_data = '0;

    // Reset state, with both sources requesting to confirm ready is held low
    step(); step();
    chk("rst_ex_ready",  {31'd0, ex_ready},  32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_we",        {31'd0, we},        32'd0);
    chk("rst_address3",  {27'd0, address3},  32'd0);
    chk("rst_wr",        wr,                 32'd0);
    ex_valid = 1'b0; mem_valid = 1'b0;
    rst_n = 1'b1;

    // Both sources valid for 4 cycles: mem, ex, mem, ex
    ex_rd = 5'd1; ex_data = 32'd54321; mem_rd = 5'd3; mem_data = 32'd7;
    ex_valid = 1'b1; mem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_mem;
      exp_mem = (k % 2 == 0);
      #1;
      chk($sformatf("rr%0d_mem_ready", k), {31'd0, mem_ready}, {31'd0, exp_mem});
      chk($sformatf("rr%0d_ex_ready", k),  {31'd0, ex_ready},  {31'd0, ~exp_mem});
      step();
      if (k == 3) begin ex_valid = 1'b0; mem_valid = 1'b0; end
      chk($sformatf("rr%0d_we", k),       {31'd0, we},       32'd1);
      chk($sformatf("rr%0d_address3", k), {27'd0, address3}, exp_mem ? 32'd3 : 32'd1);
      chk($sformatf("rr%0d_wr", k),       wr,                exp_mem ? 32'd7 : 32'd54321);
    end
    step();
    chk("rr_idle_we", {31'd0, we}, 32'd0);

    // Single load write-back to a busy register
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd2;
    #1 chk("ld_issue_stall", {31'd0, issue_stall}, 32'd0);
    step();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
    probe("ld_busy2_set", 5'd2, 1'b1);
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'd123456789;
    #1;
    chk("ld_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("ld_ex_ready",  {31'd0, ex_ready},  32'd0);
    step();
    mem_valid = 1'b0;
    chk("ld_we",       {31'd0, we},       32'd1);
    chk("ld_address3", {27'd0, address3}, 32'd2);
    chk("ld_wr",       wr,                32'd123456789);
    probe("ld_busy2_during_wr", 5'd2, 1'b1);
    step();
    chk("ld_we_after", {31'd0, we}, 32'd0);
    probe("ld_busy2_clear", 5'd2, 1'b0);

    // RAW hazard on x5: stall until the cycle after the write commits
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd5;
    #1 chk("raw_issue5_stall", {31'd0, issue_stall}, 32'd0);
    step();
    issue_rd = 5'd8; issue_rs1 = 5'd5;
    #1 chk("raw_stall_c0", {31'd0, issue_stall}, 32'd1);
    step();
    chk("raw_stall_c1", {31'd0, issue_stall}, 32'd1);
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h0000ABCD;
    #1;
    chk("raw_ex_ready",   {31'd0, ex_ready},    32'd1);
    chk("raw_stall_gnt",  {31'd0, issue_stall}, 32'd1);
    step();
    ex_valid = 1'b0;
    #1;
    chk("raw_we",         {31'd0, we},          32'd1);
    chk("raw_address3",   {27'd0, address3},    32'd5);
    chk("raw_stall_wr",   {31'd0, issue_stall}, 32'd1);
    step();
    chk("raw_unstalled",  {31'd0, issue_stall}, 32'd0);
    step();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0;
    probe("raw_busy8_set", 5'd8, 1'b1);

    // Write-back to x0 is handshaked but dropped
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFFFFFF;
    #1 chk("x0_mem_ready", {31'd0, mem_ready}, 32'd1);
    step();
    mem_valid = 1'b0;
    chk("x0_we", {31'd0, we}, 32'd0);
    probe("x0_busy0", 5'd0, 1'b0);
    probe("x0_busy8_kept", 5'd8, 1'b1);

    // Flush with x4/x6/x8 busy and a write to x7 in the output register
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd4;
    #1 chk("fl_issue4_stall", {31'd0, issue_stall}, 32'd0);
    step();
    issue_rd = 5'd6;
    #1 chk("fl_issue6_stall", {31'd0, issue_stall}, 32'd0);
    step();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
    probe("fl_busy4_set", 5'd4, 1'b1);
    probe("fl_busy6_set", 5'd6, 1'b1);
    ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'd77;
    #1 chk("fl_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 1'b0; flush = 1'b1;
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd9;
    #1;
    chk("fl_stall",    {31'd0, issue_stall}, 32'd1);
    chk("fl_we",       {31'd0, we},          32'd1);
    chk("fl_address3", {27'd0, address3},    32'd7);
    step();
    flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
    chk("fl_we_after", {31'd0, we}, 32'd0);
    probe("fl_busy4_clr", 5'd4, 1'b0);
    probe("fl_busy6_clr", 5'd6, 1'b0);
    probe("fl_busy8_clr", 5'd8, 1'b0);
    probe("fl_busy9_not_set", 5'd9, 1'b0);

    // Reset pulse one cycle after a grant drops the write and clears state
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd10;
    #1 chk("rp_issue10_stall", {31'd0, issue_stall}, 32'd0);
    step();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 5'd0;
    ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 32'd5;
    #1 chk("rp_ex_ready", {31'd0, ex_ready}, 32'd1);
    step();
    ex_valid = 1'b0;
    chk("rp_we_pending", {31'd0, we}, 32'd1);
    rst_n = 1'b0; ex_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("rp_we",        {31'd0, we},        32'd0);
    chk("rp_address3",  {27'd0, address3},  32'd0);
    chk("rp_wr",        wr,                 32'd0);
    chk("rp_ex_ready",  {31'd0, ex_ready},  32'd0);
    chk("rp_mem_ready", {31'd0, mem_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rp_prio_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("rp_prio_ex_ready",  {31'd0, ex_ready},  32'd0);
    ex_valid = 1'b0; mem_valid = 1'b0;
    probe("rp_busy10_clr", 5'd10, 1'b0);
    step();
    chk("rp_we_after", {31'd0, we}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the RV32I integer register file. It shares the register file's single write port (address3/wr/we) between two write-back sources: the ALU/execute stage and the multi-cycle load unit. Arbitration between them is round-robin. It also keeps a per-register busy scoreboard and stalls decode while any operand or destination has a write outstanding. It sits between decode, the two result producers, and the `register` block.

## Interface
Parameters:
- XLEN, 32, data width of a register.
- AW, 5, register address width (32 architectural registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_we  in  1  the instruction writes rd.
- issue_rd  in  AW  destination register.
- issue_rs1  in  AW  source register 1.
- issue_rs2  in  AW  source register 2.
- issue_stall  out  1  the instruction is not accepted this cycle.
- flush  in  1  pipeline flush; clears the scoreboard.
- ex_valid  in  1  execute result is valid.
- ex_rd  in  AW  execute destination register.
- ex_data  in  XLEN  execute result.
- ex_ready  out  1  execute result is accepted this cycle.
- mem_valid  in  1  load result is valid.
- mem_rd  in  AW  load destination register.
- mem_data  in  XLEN  load result.
- mem_ready  out  1  load result is accepted this cycle.
- address3  out  AW  register file write address.
- wr  out  XLEN  register file write data.
- we  out  1  register file write enable.

## Operation
Scoreboard:
- `busy[31:0]` holds one bit per register. `busy[0]` reads as 0 at all times.
- issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_we & busy[rd])) | flush. This is combinational.
- An issue is accepted when issue_valid & !issue_stall. If it is accepted, issue_we is 1 and rd≠0, then busy[rd] is set on the next edge.
- A committed write (we=1, address3≠0) clears busy[address3] on the edge that ends the write cycle.
- A set and a clear never target the same register in the same cycle, because an issue stalls while busy[rd] is set. If they ever collide, the clear wins.
- flush clears every busy bit on the next edge, and no issue is accepted in that cycle. A write already sitting in the output register still commits.
- A write-back to a register whose busy bit is clear is still performed, and busy is left unchanged.

Arbiter:
- A 1-bit priority pointer `prio` (0 = ex, 1 = mem) decides ties.
- If only one source is valid, that source is granted.
- If both are valid, the source named by `prio` is granted.
- After any grant, `prio` points to the source that was not granted.
- ex_ready and mem_ready are the combinational grant signals. Exactly one of them is high when any source is valid, and neither is high when no source is valid.
- A source holds valid, rd and data stable until it sees ready.
- The granted rd and data are registered into address3 and wr, and we is set to 1 on the next edge. If no grant occurs, we is 0.
- A grant to rd=0 completes the handshake but leaves we=0, so writes to x0 are dropped.

## Timing
- Reset values: we=0, address3=0, wr=0, busy=0, prio=1 (mem first).
- While rst_n=0, ex_ready and mem_ready are 0.
- Reset asserted mid-operation drops any registered write. No partial write reaches the register file.
- Latency from grant to register-file write is 1 cycle:
  - Grant in cycle N; we/address3/wr are valid during cycle N+1.
  - The register file captures the data and busy clears at the end of N+1.
  - A dependent issue is unstalled from cycle N+2.
- Throughput is one write per cycle. With both sources continuously valid, the grants alternate ex/mem.
- There is no bypass path. A source read of a busy register stalls until busy clears.

## Structure
- Shared package `rv32i_pkg` holds XLEN, AW, and localparams SRC_EX=0 and SRC_MEM=1.
- Sub-module `wb_rr_arbiter2` holds the 2-way round-robin grant logic and the `prio` register.
- The top level holds the scoreboard, the stall logic and the write output register. Expected size is about 180 lines.

## Test plan
- Reset, then mem_valid=1, mem_rd=2, mem_data=123456789 → mem_ready=1 at once. On the next cycle we=1, address3=2, wr=123456789. busy[2] clears after that edge.
- ex_valid and mem_valid held high together for 4 cycles (ex_rd=1/54321, mem_rd=3/7) → grant order mem, ex, mem, ex. we=1 for 4 consecutive cycles.
- Issue rd=5 accepted; next instruction has rs1=5 → issue_stall=1 until the cycle after the write to address3=5 commits, then 0.
- Write-back to rd=0 with data 0xFFFFFFFF → ready=1, we stays 0, busy unchanged.
- busy[4] and busy[6] set, then flush for 1 cycle → issue_stall=1 during the flush, all busy bits 0 afterwards. An in-flight write to x7 still shows we=1.
- rst_n pulsed low one cycle after a grant → we=0, no write, busy=0, prio=mem.
